machine_ws: RTL and testbench
=============================

Name: machine_ws

Overview:
Next-generation CPU main control FSM. Adds three things the fixed 8-cycle sequencer lacked: a parametrised instruction fetch length, memory wait-state handshaking with a timeout, and a sticky halt that can be resumed. It sits between the instruction register/opcode decode and the PC counter, accumulator, data_ctrl and RAM/ROM. It drives the same control strobes as before.

Parameters:
FETCH_BEATS, 2, number of instruction bytes fetched per instruction (legal 1-4).
WAIT_MAX, 15, maximum consecutive mem_rdy-low cycles in one memory state before bus error; 0 disables the timeout.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.
CNT_W, 16, width of instr_cnt (optional feature only).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  run enable from machine_ctrl; low = synchronous return to IDLE
zero  input  1  accumulator-is-zero flag
opcode  input  3  instruction opcode: HLT=0, SKZ=1, ADD=2, ANDD=3, XORR=4, LDA=5, STO=6, JMP=7
mem_rdy  input  1  memory ready; completes the current rd or wr access
resume  input  1  single-cycle pulse; leaves HALTED
inc_pc  output  1  PC increment strobe
load_acc  output  1  accumulator load
load_pc  output  1  PC parallel load
rd  output  1  memory read
wr  output  1  memory write
load_ir  output  1  instruction register load
data_ctrl_ena  output  1  drive ALU result onto the data bus
halt  output  1  processor halted
instr_done  output  1  one-cycle pulse per completed instruction
bus_err  output  1  sticky wait-state timeout

Behaviour:
- Outputs are Moore-decoded from registered state only, with no input-to-output combinational paths.
- Async reset (rst_n=0) sets: state=IDLE, beat=0, wait count=0, skip count=0, all outputs 0.
- ena=0 at a clock edge sets: state=IDLE and clears all counters. This applies from any state, including HALTED and ERR.
- IDLE: all outputs 0; moves to FETCH (beat 0) when ena=1.
- FETCH: rd=1, load_ir=1.
  - Holds while mem_rdy=0.
  - On mem_rdy=1, moves to FINC.
- FINC: inc_pc=1 for one cycle.
  - If beat<FETCH_BEATS-1: beat++ and return to FETCH.
  - Otherwise beat=0 and move to DECODE.
- DECODE: all outputs 0; opcode and zero are sampled here.
  - HLT -> HALTED.
  - SKZ with zero=1 -> SKIP.
  - SKZ with zero=0 -> DONE.
  - ADD/ANDD/XORR/LDA -> RDOP.
  - STO -> WSET.
  - JMP -> JLD.
- HALTED: halt=1, held. On resume=1 -> FETCH beat 0 (PC already points to the next instruction); instr_done is not pulsed.
- RDOP: rd=1; waits on mem_rdy, then -> ACC.
- ACC: rd=1, load_acc=1 for one cycle -> DONE.
- WSET: data_ctrl_ena=1 -> WOP.
- WOP: wr=1, data_ctrl_ena=1; waits on mem_rdy, then -> WHOLD.
- WHOLD: data_ctrl_ena=1 -> DONE.
- JLD: load_pc=1 -> JINC.
- JINC: load_pc=1, inc_pc=1 -> DONE.
- SKIP: inc_pc=1 for exactly FETCH_BEATS consecutive cycles, which skips one whole instruction -> DONE.
- DONE: instr_done=1 for one cycle -> FETCH beat 0.
- Wait counter:
  - Increments each cycle spent in FETCH, RDOP or WOP with mem_rdy=0.
  - Clears on leaving those states.
  - If WAIT_MAX>0 and the count reaches WAIT_MAX with mem_rdy still 0 -> ERR.
  - mem_rdy=1 in the same cycle the limit is reached wins: the access completes normally.
- ERR: bus_err=1, all other outputs 0; sticky until ena=0 or reset.
- resume outside HALTED is ignored. mem_rdy outside FETCH, RDOP or WOP is ignored.
- Zero-wait instruction latency in cycles:
  - ALU/LDA: 2*FETCH_BEATS+4
  - STO: 2*FETCH_BEATS+5
  - JMP: 2*FETCH_BEATS+4
  - SKZ not taken: 2*FETCH_BEATS+2
  - SKZ taken: 3*FETCH_BEATS+2
- At most one of rd/wr is high in any cycle. The FSM is never in an undefined encoding: any illegal state code goes to IDLE.

Optional Feature:
MACHINE_WS_ICNT_EN
- Defined: adds output port instr_cnt [CNT_W-1:0].
  - Increments on every DONE cycle and wraps from 2^CNT_W-1 to 0.
  - Cleared only by rst_n, not by ena.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- FETCH_BEATS=2, mem_rdy=1 constant, opcode=ADD -> rd/load_ir at cycles 1,3, inc_pc at 2,4, rd at 6, load_acc at 7, instr_done at 8, next FETCH at 9.
- FETCH_BEATS=2, opcode=SKZ, zero=1 -> inc_pc high for exactly 2 consecutive cycles after DECODE, then instr_done. With zero=0 -> no SKIP inc_pc, instr_done at cycle 6.
- opcode=HLT, resume held low 20 cycles -> halt=1 throughout, no strobes. resume pulse -> halt=0 next cycle, rd=1 (FETCH beat 0).
- STO with mem_rdy low for 3 cycles in WOP -> wr and data_ctrl_ena held 4 cycles, data_ctrl_ena also high in WSET/WHOLD, wr never overlaps rd.
- WAIT_MAX=15, mem_rdy stuck low in RDOP -> bus_err=1 after 15 wait cycles, stays high. ena=0 for one cycle -> IDLE, bus_err=0.
- rst_n asserted mid-WOP -> all outputs 0 immediately (asynchronous). With MACHINE_WS_ICNT_EN, CNT_W=4: 17 instructions -> instr_cnt=1.

Source files
------------

// File: rtl/machine_ws.sv
// machine_ws: CPU main control FSM with multi-beat fetch, wait-state timeout and resumable halt.
// Define MACHINE_WS_ICNT_EN to add the wrapping instr_cnt retired-instruction counter port.
module machine_ws #(
  parameter int FETCH_BEATS = 2,
  parameter int WAIT_MAX    = 15,
  parameter int WAIT_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             zero,
  input  logic [2:0]       opcode,
  input  logic             mem_rdy,
  input  logic             resume,
  output logic             inc_pc,
  output logic             load_acc,
  output logic             load_pc,
  output logic             rd,
  output logic             wr,
  output logic             load_ir,
  output logic             data_ctrl_ena,
  output logic             halt,
  output logic             instr_done,
  output logic             bus_err
`ifdef MACHINE_WS_ICNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FINC   = 4'd2,
    S_DECODE = 4'd3,
    S_HALTED = 4'd4,
    S_RDOP   = 4'd5,
    S_ACC    = 4'd6,
    S_WSET   = 4'd7,
    S_WOP    = 4'd8,
    S_WHOLD  = 4'd9,
    S_JLD    = 4'd10,
    S_JINC   = 4'd11,
    S_SKIP   = 4'd12,
    S_DONE   = 4'd13,
    S_ERR    = 4'd14
  } state_t;

  localparam logic [2:0] OP_HLT  = 3'd0;
  localparam logic [2:0] OP_SKZ  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ANDD = 3'd3;
  localparam logic [2:0] OP_XORR = 3'd4;
  localparam logic [2:0] OP_LDA  = 3'd5;
  localparam logic [2:0] OP_STO  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  localparam logic [1:0]        LAST_BEAT  = 2'(FETCH_BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM   = WAIT_W'(WAIT_MAX);
  localparam bit                TIMEOUT_EN = (WAIT_MAX != 0);

  // Output vector order: inc_pc, load_acc, load_pc, rd, wr, load_ir, data_ctrl_ena, halt, instr_done, bus_err
  localparam logic [9:0] O_INC  = 10'b10_0000_0000;
  localparam logic [9:0] O_LACC = 10'b01_0000_0000;
  localparam logic [9:0] O_LPC  = 10'b00_1000_0000;
  localparam logic [9:0] O_RD   = 10'b00_0100_0000;
  localparam logic [9:0] O_WR   = 10'b00_0010_0000;
  localparam logic [9:0] O_LIR  = 10'b00_0001_0000;
  localparam logic [9:0] O_DCE  = 10'b00_0000_1000;
  localparam logic [9:0] O_HALT = 10'b00_0000_0100;
  localparam logic [9:0] O_DONE = 10'b00_0000_0010;
  localparam logic [9:0] O_BERR = 10'b00_0000_0001;

  state_t            r_state;
  logic [1:0]        r_beat;
  logic [1:0]        r_skip;
  logic [WAIT_W-1:0] r_wait;
  logic [9:0]        r_out;

  state_t            w_state_next;
  logic [1:0]        w_beat_next;
  logic [1:0]        w_skip_next;
  logic [WAIT_W-1:0] w_wait_next;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_timeout;

  function automatic logic [9:0] decode_outputs(input state_t s);
    logic [9:0] v;
    v = '0;
    case (s)
      S_FETCH:  v = O_RD | O_LIR;
      S_FINC:   v = O_INC;
      S_HALTED: v = O_HALT;
      S_RDOP:   v = O_RD;
      S_ACC:    v = O_RD | O_LACC;
      S_WSET:   v = O_DCE;
      S_WOP:    v = O_WR | O_DCE;
      S_WHOLD:  v = O_DCE;
      S_JLD:    v = O_LPC;
      S_JINC:   v = O_LPC | O_INC;
      S_SKIP:   v = O_INC;
      S_DONE:   v = O_DONE;
      S_ERR:    v = O_BERR;
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Saturating so a disabled timeout never wraps back through the limit.
  assign w_wait_inc = (&r_wait) ? r_wait : r_wait + 1'b1;
  assign w_timeout  = TIMEOUT_EN && (r_wait == WAIT_LIM);

  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_skip_next  = r_skip;
    w_wait_next  = '0;
    case (r_state)
      S_IDLE: begin
        w_beat_next = '0;
        w_skip_next = '0;
        if (ena) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_rdy)        w_state_next = S_FINC;
        else if (w_timeout) w_state_next = S_ERR;
        else                w_wait_next  = w_wait_inc;
      end
      S_FINC: begin
        if (r_beat == LAST_BEAT) begin
          w_beat_next  = '0;
          w_state_next = S_DECODE;
        end else begin
          w_beat_next  = r_beat + 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_skip_next = '0;
        case (opcode)
          OP_HLT:                          w_state_next = S_HALTED;
          OP_SKZ:                          w_state_next = zero ? S_SKIP : S_DONE;
          OP_ADD, OP_ANDD, OP_XORR, OP_LDA: w_state_next = S_RDOP;
          OP_STO:                          w_state_next = S_WSET;
          OP_JMP:                          w_state_next = S_JLD;
          default:                         w_state_next = S_IDLE;
        endcase
      end
      S_HALTED: begin
        // PC already points past the HLT, so resuming just fetches the next instruction.
        if (resume) begin
          w_beat_next  = '0;
          w_state_next = S_FETCH;
        end
      end
      S_RDOP: begin
        if (mem_rdy)        w_state_next = S_ACC;
        else if (w_timeout) w_state_next = S_ERR;
        else                w_wait_next  = w_wait_inc;
      end
      S_ACC:   w_state_next = S_DONE;
      S_WSET:  w_state_next = S_WOP;
      S_WOP: begin
        if (mem_rdy)        w_state_next = S_WHOLD;
        else if (w_timeout) w_state_next = S_ERR;
        else                w_wait_next  = w_wait_inc;
      end
      S_WHOLD: w_state_next = S_DONE;
      S_JLD:   w_state_next = S_JINC;
      S_JINC:  w_state_next = S_DONE;
      S_SKIP: begin
        if (r_skip == LAST_BEAT) begin
          w_skip_next  = '0;
          w_state_next = S_DONE;
        end else begin
          w_skip_next  = r_skip + 1'b1;
        end
      end
      S_DONE: begin
        w_beat_next  = '0;
        w_state_next = S_FETCH;
      end
      S_ERR:   w_state_next = S_ERR;
      default: begin
        w_beat_next  = '0;
        w_skip_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
    if (!ena) begin
      w_state_next = S_IDLE;
      w_beat_next  = '0;
      w_skip_next  = '0;
      w_wait_next  = '0;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_skip  <= '0;
      r_wait  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
      r_skip  <= w_skip_next;
      r_wait  <= w_wait_next;
      r_out   <= decode_outputs(w_state_next);
    end
  end

  assign inc_pc        = r_out[9];
  assign load_acc      = r_out[8];
  assign load_pc       = r_out[7];
  assign rd            = r_out[6];
  assign wr            = r_out[5];
  assign load_ir       = r_out[4];
  assign data_ctrl_ena = r_out[3];
  assign halt          = r_out[2];
  assign instr_done    = r_out[1];
  assign bus_err       = r_out[0];

`ifdef MACHINE_WS_ICNT_EN
  logic [CNT_W-1:0] r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (r_state == S_DONE) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_machine_ws.sv
// tb_machine_ws: directed self-checking bench for machine_ws (FETCH_BEATS=2, WAIT_MAX=15).
// With MACHINE_WS_ICNT_EN defined the instr_cnt wrap check runs with CNT_W=4.
module tb_machine_ws;
  localparam int FB    = 2;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [9:0] O_INC  = 10'h200;
  localparam logic [9:0] O_LACC = 10'h100;
  localparam logic [9:0] O_LPC  = 10'h080;
  localparam logic [9:0] O_RD   = 10'h040;
  localparam logic [9:0] O_WR   = 10'h020;
  localparam logic [9:0] O_LIR  = 10'h010;
  localparam logic [9:0] O_DCE  = 10'h008;
  localparam logic [9:0] O_HALT = 10'h004;
  localparam logic [9:0] O_DONE = 10'h002;
  localparam logic [9:0] O_BERR = 10'h001;
  localparam logic [9:0] O_FET  = O_RD | O_LIR;

  logic clk = 1'b0;
  logic rst_n, ena, zero, mem_rdy, resume;
  logic [2:0] opcode;
  logic inc_pc, load_acc, load_pc, rd, wr, load_ir, data_ctrl_ena, halt, instr_done, bus_err;
`ifdef MACHINE_WS_ICNT_EN
  logic [CNT_W-1:0] instr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wire [9:0] obs = {inc_pc, load_acc, load_pc, rd, wr, load_ir, data_ctrl_ena, halt, instr_done, bus_err};

  always #5 clk = ~clk;

  machine_ws #(.FETCH_BEATS(FB), .WAIT_MAX(15), .WAIT_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .zero(zero), .opcode(opcode),
    .mem_rdy(mem_rdy), .resume(resume),
    .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
    .load_ir(load_ir), .data_ctrl_ena(data_ctrl_ena), .halt(halt),
    .instr_done(instr_done), .bus_err(bus_err)
`ifdef MACHINE_WS_ICNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE, one tick after reset release, all inputs low.
  task automatic reset_dut();
    rst_n = 1'b0; ena = 1'b0; zero = 1'b0; opcode = 3'd0; mem_rdy = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; mem_rdy = 1'b1; opcode = OP_ADD; zero = 1'b0; resume = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== 10'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 10'h000);
    end
    reset_dut();
    checks++;
    if (obs !== 10'h000) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected %b", obs, 10'h000);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    logic [9:0] exp [1:9];
    exp = '{O_FET, O_INC, O_FET, O_INC, 10'h000, O_RD, O_RD | O_LACC, O_DONE, O_FET};
    reset_dut();
    opcode = OP_ADD; mem_rdy = 1'b1; ena = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("FAIL alu cycle %0d: got %b expected %b", c, obs, exp[c]);
      end
    end
    $display("test_alu done");
  endtask

  task automatic test_skz();
    logic [9:0] exp_t [1:9];
    logic [9:0] exp_n [1:7];
    exp_t = '{O_FET, O_INC, O_FET, O_INC, 10'h000, O_INC, O_INC, O_DONE, O_FET};
    exp_n = '{O_FET, O_INC, O_FET, O_INC, 10'h000, O_DONE, O_FET};
    reset_dut();
    opcode = OP_SKZ; zero = 1'b1; mem_rdy = 1'b1; ena = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL skz_taken cycle %0d: got %b expected %b", c, obs, exp_t[c]);
      end
    end
    reset_dut();
    opcode = OP_SKZ; zero = 1'b0; mem_rdy = 1'b1; ena = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (obs !== exp_n[c]) begin
        errors++;
        $display("FAIL skz_not_taken cycle %0d: got %b expected %b", c, obs, exp_n[c]);
      end
    end
    $display("test_skz done");
  endtask

  // resume is held high throughout: it must be ignored outside HALTED.
  task automatic test_jmp();
    logic [9:0] exp [1:9];
    exp = '{O_FET, O_INC, O_FET, O_INC, 10'h000, O_LPC, O_LPC | O_INC, O_DONE, O_FET};
    reset_dut();
    opcode = OP_JMP; mem_rdy = 1'b1; resume = 1'b1; ena = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("FAIL jmp cycle %0d: got %b expected %b", c, obs, exp[c]);
      end
    end
    resume = 1'b0;
    $display("test_jmp done");
  endtask

  task automatic test_halt();
    reset_dut();
    opcode = OP_HLT; mem_rdy = 1'b1; ena = 1'b1;
    repeat (6) tick();
    checks++;
    if (obs !== O_HALT) begin
      errors++;
      $display("FAIL halt_entry: got %b expected %b", obs, O_HALT);
    end
    for (int c = 0; c < 20; c++) begin
      mem_rdy = c[0];
      opcode  = c[2:0];
      tick();
      checks++;
      if (obs !== O_HALT) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %b expected %b", c, obs, O_HALT);
      end
    end
    mem_rdy = 1'b1; opcode = OP_ADD;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (obs !== O_FET) begin
      errors++;
      $display("FAIL halt_resume: got %b expected %b", obs, O_FET);
    end
    tick();
    checks++;
    if (obs !== O_INC) begin
      errors++;
      $display("FAIL halt_resume_finc: got %b expected %b", obs, O_INC);
    end
    $display("test_halt done");
  endtask

  task automatic test_sto_wait();
    logic [9:0] exp [1:13];
    exp = '{O_FET, O_INC, O_FET, O_INC, 10'h000, O_DCE, O_WR | O_DCE, O_WR | O_DCE,
            O_WR | O_DCE, O_WR | O_DCE, O_DCE, O_DONE, O_FET};
    reset_dut();
    opcode = OP_STO; ena = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      mem_rdy = !((c - 1) >= 7 && (c - 1) <= 9);
      tick();
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("FAIL sto_wait cycle %0d: got %b expected %b", c, obs, exp[c]);
      end
      checks++;
      if ((rd & wr) !== 1'b0) begin
        errors++;
        $display("FAIL rd_wr_overlap cycle %0d: got rd=%b wr=%b expected not both", c, rd, wr);
      end
    end
    $display("test_sto_wait done");
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    reset_dut();
    opcode = OP_ADD; ena = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      mem_rdy = ((c - 1) < 6) || ((c - 1) >= 22);
      if (c <= 4)       e = c[0] ? O_FET : O_INC;
      else if (c == 5)  e = 10'h000;
      else if (c <= 21) e = O_RD;
      else              e = O_BERR;
      tick();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %b expected %b", c, obs, e);
      end
    end
    ena = 1'b0;
    tick();
    checks++;
    if (obs !== 10'h000) begin
      errors++;
      $display("FAIL err_clear_by_ena: got %b expected %b", obs, 10'h000);
    end
    ena = 1'b1;
    tick();
    checks++;
    if (obs !== O_FET) begin
      errors++;
      $display("FAIL restart_after_err: got %b expected %b", obs, O_FET);
    end
    $display("test_timeout done");
  endtask

  // mem_rdy arrives in the very cycle the wait count hits the limit: the read completes.
  task automatic test_timeout_boundary();
    logic [9:0] e;
    reset_dut();
    opcode = OP_ADD; ena = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      mem_rdy = ((c - 1) < 6) || ((c - 1) == 21);
      if (c <= 4)       e = c[0] ? O_FET : O_INC;
      else if (c == 5)  e = 10'h000;
      else if (c <= 21) e = O_RD;
      else if (c == 22) e = O_RD | O_LACC;
      else if (c == 23) e = O_DONE;
      else              e = O_FET;
      tick();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout_boundary cycle %0d: got %b expected %b", c, obs, e);
      end
    end
    $display("test_timeout_boundary done");
  endtask

  task automatic test_ena_drop();
    reset_dut();
    opcode = OP_ADD; mem_rdy = 1'b0; ena = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== O_FET) begin
      errors++;
      $display("FAIL fetch_hold: got %b expected %b", obs, O_FET);
    end
    ena = 1'b0;
    tick();
    checks++;
    if (obs !== 10'h000) begin
      errors++;
      $display("FAIL ena_drop: got %b expected %b", obs, 10'h000);
    end
    $display("test_ena_drop done");
  endtask

  task automatic test_async_reset();
    reset_dut();
    opcode = OP_STO; ena = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      mem_rdy = ((c - 1) < 7);
      tick();
    end
    checks++;
    if (obs !== (O_WR | O_DCE)) begin
      errors++;
      $display("FAIL wop_before_reset: got %b expected %b", obs, O_WR | O_DCE);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 10'h000) begin
      errors++;
      $display("FAIL async_reset_mid_wop: got %b expected %b", obs, 10'h000);
    end
    rst_n = 1'b1;
    $display("test_async_reset done");
  endtask

`ifdef MACHINE_WS_ICNT_EN
  task automatic test_icnt();
    int done_cnt;
    logic [CNT_W-1:0] cnt_at_17;
    done_cnt  = 0;
    cnt_at_17 = '1;
    reset_dut();
    opcode = OP_SKZ; zero = 1'b0; mem_rdy = 1'b1; ena = 1'b1;
    for (int c = 0; c < 400 && done_cnt < 17; c++) begin
      tick();
      if (instr_done) begin
        done_cnt++;
        if (done_cnt == 17) cnt_at_17 = instr_cnt;
      end
    end
    checks++;
    if (done_cnt != 17) begin
      errors++;
      $display("FAIL icnt_timeout: got %0d instr_done pulses expected 17", done_cnt);
    end
    checks++;
    if (cnt_at_17 !== 4'd0) begin
      errors++;
      $display("FAIL icnt_before_17th: got %0d expected 0", cnt_at_17);
    end
    ena = 1'b0;
    tick();
    checks++;
    if (instr_cnt !== 4'd1) begin
      errors++;
      $display("FAIL icnt_wrap: got %0d expected 1", instr_cnt);
    end
    tick();
    checks++;
    if (instr_cnt !== 4'd1) begin
      errors++;
      $display("FAIL icnt_kept_on_ena_low: got %0d expected 1", instr_cnt);
    end
    $display("test_icnt done");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; zero = 1'b0; opcode = 3'd0; mem_rdy = 1'b0; resume = 1'b0;
    test_reset();
    test_alu();
    test_skz();
    test_jmp();
    test_halt();
    test_sto_wait();
    test_timeout();
    test_timeout_boundary();
    test_ena_drop();
    test_async_reset();
`ifdef MACHINE_WS_ICNT_EN
    test_icnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
